// File: rtl/mips_wb_pkg.sv
// Shared opcode constants, FSM/source enums and the writeback decoder
// for the multicycle MIPS writeback sequencer.
package mips_wb_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  localparam logic [4:0] RI_BLTZAL  = 5'h10;
  localparam logic [4:0] RI_BGEZAL  = 5'h11;

  typedef enum logic [1:0] {
    IDLE, WAIT_MEM, WRITE, DONE
  } wb_state_t;

  typedef enum logic [1:0] {
    SRC_ALU, SRC_MEM, SRC_LINK
  } wb_src_t;

  typedef struct packed {
    logic       wr;
    wb_src_t    src;
    logic [4:0] dest;
  } wb_dec_t;

  function automatic wb_dec_t wb_decode(input logic [31:0] ins);
    wb_dec_t    d;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    op     = ins[31:26];
    fn     = ins[5:0];
    rt     = ins[20:16];
    d.wr   = 1'b1;
    d.src  = SRC_ALU;
    d.dest = rt;
    unique case (1'b1)
      (op == OP_SPECIAL): begin
        d.dest = ins[15:11];
        if (fn == FN_JALR)
          d.src = SRC_LINK;
        else if (fn inside {FN_JR, FN_SYSCALL, FN_BREAK,
                            FN_MTHI, FN_MTLO, FN_MULT,
                            FN_MULTU, FN_DIV, FN_DIVU})
          d.wr = 1'b0;
      end
      (op == OP_REGIMM): begin
        if (rt inside {RI_BLTZAL, RI_BGEZAL}) begin
          d.dest = 5'd31;
          d.src  = SRC_LINK;
        end else begin
          d.wr = 1'b0;
        end
      end
      (op == OP_JAL): begin
        d.dest = 5'd31;
        d.src  = SRC_LINK;
      end
      (op inside {OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
                  OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR}):
        d.wr = 1'b0;
      (op inside {OP_LB, OP_LH, OP_LWL, OP_LW,
                  OP_LBU, OP_LHU, OP_LWR}):
        d.src = SRC_MEM;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_load_align.sv
// Little-endian load lane selection, extension and LWL/LWR merge
// of the returned memory word into the old rt value.
module mips_load_align
  import mips_wb_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] old_rt,
  output logic [31:0] load_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = mem_rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    unique case (opcode)
      OP_LB:  load_data = {{24{b[7]}}, b};
      OP_LBU: load_data = {24'd0, b};
      OP_LH:  load_data = {{16{h[15]}}, h};
      OP_LHU: load_data = {16'd0, h};
      OP_LWL: begin
        case (addr_lo)
          2'd0: load_data = {mem_rdata[7:0], old_rt[23:0]};
          2'd1: load_data = {mem_rdata[15:0], old_rt[15:0]};
          2'd2: load_data = {mem_rdata[23:0], old_rt[7:0]};
          2'd3: load_data = mem_rdata;
        endcase
      end
      OP_LWR: begin
        case (addr_lo)
          2'd0: load_data = mem_rdata;
          2'd1: load_data = {old_rt[31:24], mem_rdata[31:8]};
          2'd2: load_data = {old_rt[31:16], mem_rdata[31:16]};
          2'd3: load_data = {old_rt[31:8], mem_rdata[31:24]};
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_writeback_ctrl.sv
// Writeback sequencer driving the register-file write port and commit.
// Optional WB_BYPASS_EN adds byp_valid/byp_addr/byp_data forwarding ports.
module mips_writeback_ctrl
  import mips_wb_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned LINK_OFFSET = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc,
  input  logic [31:0] old_rt,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        commit,
  output logic        mem_err
`ifdef WB_BYPASS_EN
  ,
  output logic        byp_valid,
  output logic [4:0]  byp_addr,
  output logic [31:0] byp_data
`endif
);

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  wb_state_t   state_q, state_d;
  wb_dec_t     dec;
  logic [5:0]  op_q;
  logic [1:0]  alo_q;
  logic [31:0] old_rt_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic [15:0] cnt_q, cnt_inc;
  logic        err_q;
  logic        xfer, ld_hit, abort;
  logic [31:0] ld_val;

  assign dec = wb_decode(instr);

  mips_load_align u_align (
    .opcode    (op_q),
    .addr_lo   (alo_q),
    .mem_rdata (mem_rdata),
    .old_rt    (old_rt_q),
    .load_data (ld_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_inc = cnt_q + 16'd1;
    xfer    = 1'b0;
    ld_hit  = 1'b0;
    abort   = 1'b0;
    if (active) begin
      unique case (state_q)
        IDLE: if (wb_valid) begin
          xfer = 1'b1;
          if (!dec.wr)
            state_d = DONE;
          else if (dec.src == SRC_MEM)
            state_d = WAIT_MEM;
          else
            state_d = WRITE;
        end
        // a response on the expiry cycle still completes the load
        WAIT_MEM: if (mem_rvalid) begin
          ld_hit  = 1'b1;
          state_d = WRITE;
        end else if (MEM_TIMEOUT != 0 && cnt_inc == TMO) begin
          abort   = 1'b1;
          state_d = DONE;
        end
        WRITE:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      alo_q    <= '0;
      old_rt_q <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        op_q     <= instr[31:26];
        alo_q    <= addr_lo;
        old_rt_q <= old_rt;
        waddr_q  <= dec.wr ? dec.dest : 5'd0;
        wdata_q  <= (dec.src == SRC_LINK)
                    ? pc + 32'(LINK_OFFSET) : alu_result;
        cnt_q    <= '0;
        err_q    <= 1'b0;
      end
      if (active && state_q == WAIT_MEM)
        cnt_q <= cnt_inc;
      if (ld_hit)
        wdata_q <= ld_val;
      if (abort)
        err_q <= 1'b1;
    end
  end

  assign wb_ready = (state_q == IDLE);
  assign rf_we    = active && state_q == WRITE && waddr_q != 5'd0;
  assign commit   = active && state_q == DONE;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign mem_err  = err_q;

`ifdef WB_BYPASS_EN
  assign byp_valid = (state_q == WRITE || state_q == DONE)
                     && waddr_q != 5'd0 && !err_q;
  assign byp_addr  = waddr_q;
  assign byp_data  = wdata_q;
`endif

endmodule
